// File: rtl/operand_entry_sequencer.sv
// Front end of the add/multiply datapath: synchronises and debounces the four
// operation buttons, then steps operand/opcode entry from the switches.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | waiting for first press, captures num1
// ST_WAIT1  | num1 held, next press captures num2
// ST_WAIT2  | num1/num2 held, next press captures op
// ST_RESULT | entry complete, presses ignored until reset
module operand_entry_sequencer #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] sw,
    input  logic        btn_fla,
    input  logic        btn_flm,
    input  logic        btn_fia,
    input  logic        btn_fim,
    output logic [15:0] num1,
    output logic [15:0] num2,
    output logic [1:0]  op,
    output logic [1:0]  state,
    output logic        result_valid
);

    localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_WAIT1  = 2'b01,
        ST_WAIT2  = 2'b10,
        ST_RESULT = 2'b11
    } state_t;

    // Bit order {fim, fia, flm, fla} matches the op encoding.
    logic [3:0]         btn_raw;
    logic [3:0]         sync1_q, sync1_d;
    logic [3:0]         sync2_q, sync2_d;
    logic [3:0]         stable_q, stable_d;
    logic [3:0]         stable_prev_q, stable_prev_d;
    logic [3:0][CW-1:0] cnt_q, cnt_d;
    logic [3:0]         press;
    logic               any_press;
    logic [1:0]         op_enc;

    state_t      state_q, state_d;
    logic [15:0] num1_q, num1_d;
    logic [15:0] num2_q, num2_d;
    logic [1:0]  op_q, op_d;

    assign btn_raw = {btn_fim, btn_fia, btn_flm, btn_fla};

    always_comb begin
        sync1_d       = btn_raw;
        sync2_d       = sync1_q;
        stable_prev_d = stable_q;
        stable_d      = stable_q;
        cnt_d         = '0;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] != stable_q[i]) begin
                // Counter returns to zero on the flip, so a new run starts clean.
                if (cnt_q[i] + CW'(1) == CNT_TC) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    assign press     = stable_q & ~stable_prev_q;
    assign any_press = |press;

    always_comb begin
        if (press[3])      op_enc = 2'b11;
        else if (press[2]) op_enc = 2'b10;
        else if (press[1]) op_enc = 2'b01;
        else               op_enc = 2'b00;
    end

    always_comb begin
        state_d = state_q;
        num1_d  = num1_q;
        num2_d  = num2_q;
        op_d    = op_q;
        case (state_q)
            ST_IDLE: begin
                if (any_press) begin
                    state_d = ST_WAIT1;
                    num1_d  = sw;
                end
            end
            ST_WAIT1: begin
                if (any_press) begin
                    state_d = ST_WAIT2;
                    num2_d  = sw;
                end
            end
            ST_WAIT2: begin
                if (any_press) begin
                    state_d = ST_RESULT;
                    op_d    = op_enc;
                end
            end
            ST_RESULT: begin
                state_d = ST_RESULT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            cnt_q         <= '0;
            state_q       <= ST_IDLE;
            num1_q        <= '0;
            num2_q        <= '0;
            op_q          <= '0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_prev_d;
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            num1_q        <= num1_d;
            num2_q        <= num2_d;
            op_q          <= op_d;
        end
    end

    assign num1         = num1_q;
    assign num2         = num2_q;
    assign op           = op_q;
    assign state        = state_q;
    assign result_valid = (state_q == ST_RESULT);

endmodule

// File: tb/tb_operand_entry_sequencer.sv
// Bench for operand_entry_sequencer: expected entry snapshots are queued as
// buttons are driven and popped whenever the DUT state output changes.
module tb_operand_entry_sequencer;

    logic        clk;
    logic        rst;
    logic [15:0] sw;
    logic        btn_fla, btn_flm, btn_fia, btn_fim;
    logic [15:0] num1, num2;
    logic [1:0]  op, state;
    logic        result_valid;

    typedef struct packed {
        logic [1:0]  st;
        logic [15:0] n1;
        logic [15:0] n2;
        logic [1:0]  op;
        logic        rv;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic        mon_en   = 1'b0;
    logic [1:0]  last_state;

    operand_entry_sequencer #(.DEBOUNCE_CYCLES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .sw           (sw),
        .btn_fla      (btn_fla),
        .btn_flm      (btn_flm),
        .btn_fia      (btn_fia),
        .btn_fim      (btn_fim),
        .num1         (num1),
        .num2         (num2),
        .op           (op),
        .state        (state),
        .result_valid (result_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_btns(input logic [3:0] b);
        {btn_fim, btn_fia, btn_flm, btn_fla} = b;
    endtask

    task automatic press(input logic [3:0] b, input int n_high);
        set_btns(b);
        repeat (n_high) tick();
        set_btns(4'b0000);
        repeat (12) tick();
    endtask

    task automatic push(input logic [1:0] st, input logic [15:0] n1, input logic [15:0] n2,
                        input logic [1:0] o);
        exp_t e;
        e.st = st; e.n1 = n1; e.n2 = n2; e.op = o; e.rv = (st == 2'b11);
        exp_q.push_back(e);
    endtask

    // Scoreboard: every state change must match the next queued snapshot.
    always @(negedge clk) begin
        if (mon_en && state !== last_state) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_state", {30'b0, state}, {30'b0, last_state});
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_state", {30'b0, state}, {30'b0, e.st});
                chk("sb_num1", {16'b0, num1}, {16'b0, e.n1});
                chk("sb_num2", {16'b0, num2}, {16'b0, e.n2});
                chk("sb_op", {30'b0, op}, {30'b0, e.op});
                chk("sb_rv", {31'b0, result_valid}, {31'b0, e.rv});
            end
            last_state = state;
        end
    end

    initial begin
        rst = 1'b0;
        sw  = 16'hFFFF;
        set_btns(4'b1111);
        repeat (2) tick();
        chk("rst_state", {30'b0, state}, 32'h0);
        chk("rst_num1", {16'b0, num1}, 32'h0);
        chk("rst_num2", {16'b0, num2}, 32'h0);
        chk("rst_op", {30'b0, op}, 32'h0);
        chk("rst_rv", {31'b0, result_valid}, 32'h0);

        rst = 1'b1;
        sw  = 16'h0000;
        set_btns(4'b0000);
        repeat (12) tick();
        chk("idle_after_rst", {30'b0, state}, 32'h0);
        last_state = state;
        mon_en     = 1'b1;

        // Full sequence, with exact latency on the first press.
        sw = 16'h3C00;
        push(2'b01, 16'h3C00, 16'h0000, 2'b00);
        set_btns(4'b0001);
        repeat (6) tick();
        chk("pre_edge7_state", {30'b0, state}, 32'h0);
        tick();
        chk("edge7_state", {30'b0, state}, 32'h1);
        chk("edge7_num1", {16'b0, num1}, 32'h3C00);
        repeat (3) tick();
        set_btns(4'b0000);
        sw = 16'hFFFF;
        repeat (12) tick();
        chk("num1_hold_sw", {16'b0, num1}, 32'h3C00);

        sw = 16'h4000;
        push(2'b10, 16'h3C00, 16'h4000, 2'b00);
        press(4'b0010, 10);
        sw = 16'h0000;

        push(2'b11, 16'h3C00, 16'h4000, 2'b11);
        press(4'b1000, 10);
        chk("result_rv", {31'b0, result_valid}, 32'h1);

        // Glitch in IDLE after reset.
        push(2'b00, 16'h0000, 16'h0000, 2'b00);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        repeat (4) tick();
        sw = 16'hAAAA;
        press(4'b0100, 3);
        chk("glitch_state", {30'b0, state}, 32'h0);
        chk("glitch_num1", {16'b0, num1}, 32'h0);

        // Bouncing button then steady hold: one advance only.
        sw = 16'h1111;
        push(2'b01, 16'h1111, 16'h0000, 2'b00);
        for (int i = 0; i < 5; i++) begin
            set_btns(4'b0001);
            repeat (2) tick();
            set_btns(4'b0000);
            repeat (2) tick();
        end
        press(4'b0001, 30);
        chk("bounce_state", {30'b0, state}, 32'h1);
        chk("bounce_num1", {16'b0, num1}, 32'h1111);

        // Simultaneous fla+fia in WAIT2, then ignored presses in RESULT.
        sw = 16'h5678;
        push(2'b10, 16'h1111, 16'h5678, 2'b00);
        press(4'b0010, 10);
        sw = 16'h9999;
        push(2'b11, 16'h1111, 16'h5678, 2'b10);
        press(4'b0101, 10);
        press(4'b1000, 10);
        press(4'b0001, 10);
        chk("result_hold_op", {30'b0, op}, 32'h2);
        chk("result_hold_num1", {16'b0, num1}, 32'h1111);
        chk("result_hold_num2", {16'b0, num2}, 32'h5678);

        // Reset mid-entry from WAIT2.
        push(2'b00, 16'h0000, 16'h0000, 2'b00);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        repeat (4) tick();
        sw = 16'h1234;
        push(2'b01, 16'h1234, 16'h0000, 2'b00);
        press(4'b0100, 10);
        sw = 16'h5678;
        push(2'b10, 16'h1234, 16'h5678, 2'b00);
        press(4'b1000, 10);
        push(2'b00, 16'h0000, 16'h0000, 2'b00);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("midrst_state", {30'b0, state}, 32'h0);
        chk("midrst_num1", {16'b0, num1}, 32'h0);
        chk("midrst_num2", {16'b0, num2}, 32'h0);
        chk("midrst_op", {30'b0, op}, 32'h0);
        repeat (4) tick();

        chk("sb_drained", exp_q.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/operand_entry_sequencer.md
Name: operand_entry_sequencer

Overview:
- Front-end stage of the fixed/floating add-multiply datapath.
- Synchronises and debounces the four operation buttons and turns each press into a single-cycle event.
- Steps an entry FSM (IDLE, WAIT1, WAIT2, RESULT) that captures operand 1, operand 2 and the operation code from the switches.
- Outputs num1, num2, op and state feed the arithmetic units, result mux and status LEDs directly.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive cycles a synchronised button level must differ from the stable level before the stable level flips (2.5 ms at 100 MHz); minimum 1.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-low reset (rst=0 resets on the next rising clk edge)
sw  in  16  operand switches
btn_fla  in  1  raw floating-add button, asynchronous, active-high
btn_flm  in  1  raw floating-multiply button, asynchronous, active-high
btn_fia  in  1  raw fixed-add button, asynchronous, active-high
btn_fim  in  1  raw fixed-multiply button, asynchronous, active-high
num1  out  16  captured first operand
num2  out  16  captured second operand
op  out  2  operation: 00 float add, 01 float mult, 10 fixed add, 11 fixed mult
state  out  2  FSM state: 00 IDLE, 01 WAIT1, 10 WAIT2, 11 RESULT
result_valid  out  1  high while state==RESULT

Behaviour:
- Reset (rst=0 at an edge) clears the following to 0:
  - state, num1, num2, op
  - all synchroniser flops, stable levels and debounce counters
  - result_valid, therefore 0
- Reset takes priority over any press pulse in the same cycle.
- Synchroniser: 2-flop chain per button; the second flop is the synchronised level s.
- Debounce, per button, counter width ceil(log2(DEBOUNCE_CYCLES+1)):
  - if s==stable, the counter clears;
  - otherwise it increments;
  - when it would reach DEBOUNCE_CYCLES, stable<=s and the counter clears.
  - Any s pulse shorter than DEBOUNCE_CYCLES cycles leaves stable unchanged.
- Press pulse: high for exactly one cycle when stable rises (stable=1, previous stable=0). Release generates nothing.
- Latency: raw input high and set up before edge 1, held steady:
  - stable high after edge DEBOUNCE_CYCLES+2;
  - FSM/register update at edge DEBOUNCE_CYCLES+3.
- any_press = OR of the four pulses.
- FSM, advancing only on any_press:
  - IDLE -> WAIT1, num1<=sw
  - WAIT1 -> WAIT2, num2<=sw
  - WAIT2 -> RESULT, op<=encoded button
  - RESULT: terminal; presses ignored; num1, num2 and op held until reset.
- sw is sampled only in the pulse cycle. Switch changes at other times have no effect.
- Op encoding priority when several pulses coincide in WAIT2: fim(11) > fia(10) > flm(01) > fla(00).
- Which button advances IDLE->WAIT1 or WAIT1->WAIT2 is irrelevant; any button advances.
- Simultaneous pulses count as one press. The FSM advances exactly one state per cycle.
- A button held high across reset release is seen as a fresh press after debounce latency (stable reset to 0).
- Reset mid-entry (any state): all captured values are lost and the FSM returns to IDLE with outputs zero.
- Register hold: num1, num2 and op change only at their capture transitions.
- Output registers: all outputs are registered, except result_valid, which is decoded from the state register.

Test Plan:
(bench DEBOUNCE_CYCLES=4)
- Reset: rst=0 two cycles with all buttons high -> state=00, num1=num2=0, op=00, result_valid=0.
- Full sequence:
  - sw=16'h3C00, press fla 10 cycles -> state=01 exactly at edge 7 after press, num1=3C00;
  - sw=16'h4000, press flm -> state=10, num2=4000;
  - press fim -> state=11, op=11, result_valid=1.
- Glitch: btn_fia high 3 cycles in IDLE -> no pulse, state stays 00, num1 unchanged.
- Held/bounce: btn_fla toggles 1/0 every 2 cycles for 20 cycles then holds high 30 cycles -> exactly one state advance.
- Simultaneous: in WAIT2, btn_fla and btn_fia rise same cycle -> op=10, single transition to RESULT; further presses in RESULT change nothing.
- Reset mid-entry: in WAIT2 with num1=1234, num2=5678, drive rst=0 one cycle -> state=00, num1=num2=0, op=00 next cycle.
